fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 131 +++++++++++++
 tb/tb_fetch_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer (BOOT/FETCH/DELIVER/HALT); define FETCH_BUF_EN for a two-entry fetch buffer
module fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] pc_i,
    output logic        pc_write_o,
    output logic [31:0] next_pc_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        fault_o
);
    typedef enum logic [1:0] {BOOT, FETCH, DELIVER, HALT} state_e;
    state_e state_q, state_d;
    logic pending_q, pending_d, fault_q, fault_d;
    logic active, redir_ok, redir_bad, take, room, pcw;
`ifdef FETCH_BUF_EN
    localparam state_e AFTER_TAKE = FETCH;
`else
    localparam state_e AFTER_TAKE = DELIVER;
`endif
    assign active      = (state_q == FETCH) || (state_q == DELIVER);
    assign redir_ok    = active & redirect_i & (redirect_pc_i[1:0] == 2'b00);
    assign redir_bad   = active & redirect_i & (redirect_pc_i[1:0] != 2'b00);
    assign imem_req_o  = (state_q == FETCH) & ~redirect_i & (pending_q | (~stall_i & room));
    assign take        = imem_req_o & imem_ready_i;
    assign imem_addr_o = pc_i;
    assign pc_write_o  = pcw & rst_ni;
    assign fault_o     = fault_q;
    // state, outstanding-request and sticky fault registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= BOOT;
            pending_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            fault_q   <= fault_d;
        end
    end
    // next state and PC update; a redirect overrides every other event
    always_comb begin
        state_d   = state_q;
        fault_d   = fault_q;
        pending_d = imem_req_o & ~imem_ready_i;
        pcw       = 1'b0;
        next_pc_o = pc_i + 32'd4;
        if (state_q == BOOT) begin
            pcw       = 1'b1;
            next_pc_o = RESET_VECTOR;
            state_d   = FETCH;
        end else if (redir_bad) begin
            fault_d = 1'b1;
            state_d = HALT;
        end else if (redir_ok) begin
            pcw       = 1'b1;
            next_pc_o = redirect_pc_i;
            state_d   = FETCH;
        end else if (take) begin
            pcw     = 1'b1;
            state_d = AFTER_TAKE;
        end else if (state_q == DELIVER && instr_ready_i) begin
            state_d = FETCH;
        end
    end
`ifdef FETCH_BUF_EN
    logic [31:0] buf_instr_q [2];
    logic [31:0] buf_pc_q [2];
    logic [1:0]  count_q;
    logic        rd_q, wr_q, pop;
    assign room          = count_q != 2'd2;
    assign instr_valid_o = count_q != 2'd0;
    assign pop           = instr_valid_o & instr_ready_i & ~redirect_i;
    assign instr_o       = buf_instr_q[rd_q];
    assign instr_pc_o    = buf_pc_q[rd_q];
    // two-entry FIFO toward decode, flushed by any redirect
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_instr_q <= '{default: '0};
            buf_pc_q    <= '{default: '0};
            count_q     <= 2'd0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
        end else if (redirect_i) begin
            count_q <= 2'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            if (take) begin
                buf_instr_q[wr_q] <= imem_rdata_i;
                buf_pc_q[wr_q]    <= pc_i;
                wr_q              <= ~wr_q;
            end
            if (pop) rd_q <= ~rd_q;
            count_q <= count_q + {1'b0, take} - {1'b0, pop};
        end
    end
`else
    logic        valid_q;
    logic [31:0] instr_q, instr_pc_q;
    assign room          = 1'b1;
    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    // single holding register toward decode
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q    <= 1'b0;
            instr_q    <= 32'd0;
            instr_pc_q <= 32'd0;
        end else begin
            if (take) begin
                instr_q    <= imem_rdata_i;
                instr_pc_q <= pc_i;
            end
            valid_q <= ~redirect_i & (take | (valid_q & ~instr_ready_i));
        end
    end
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl with a behavioural PC register and memory
module tb_fetch_ctrl;
    logic        clk, rst_n, pc_write, imem_req, imem_ready, instr_valid, instr_ready;
    logic        stall, redirect, fault;
    logic [31:0] pc, next_pc, imem_addr, imem_rdata, instr, instr_pc, redirect_pc;
    int n_cmp = 0;
    int n_err = 0;

    fetch_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n), .pc_i(pc), .pc_write_o(pc_write), .next_pc_o(next_pc),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_ready_i(imem_ready),
        .imem_rdata_i(imem_rdata), .instr_valid_o(instr_valid), .instr_o(instr),
        .instr_pc_o(instr_pc), .instr_ready_i(instr_ready), .stall_i(stall),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc), .fault_o(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // program counter register outside the block; garbage reset value proves BOOT loads the vector
    always @(posedge clk or negedge rst_n)
        if (!rst_n) pc <= 32'h0000_1230;
        else if (pc_write) pc <= next_pc;

    // memory contents: word at A reads A ^ 32'hA5A5_0000
    assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

    task automatic start(input logic rdy);
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        instr_ready = 1'b1; imem_ready = rdy;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1; #1;
    endtask

    task automatic step;
        @(negedge clk); #1;
    endtask

    task automatic test_reset;
        start(1'b0);
        n_cmp++; if (pc_write !== 1'b1) begin n_err++; $display("FAIL boot_pc_write got %b want 1", pc_write); end
        n_cmp++; if (next_pc !== 32'h0) begin n_err++; $display("FAIL boot_next_pc got %h want 00000000", next_pc); end
        step;
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL first_req got %b want 1", imem_req); end
        rst_n = 1'b0; #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %b want 0", imem_req); end
        n_cmp++; if (pc_write !== 1'b0) begin n_err++; $display("FAIL rst_pc_write got %b want 0", pc_write); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", instr_valid); end
        n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL rst_fault got %b want 0", fault); end
        n_cmp++; if (instr !== 32'h0) begin n_err++; $display("FAIL rst_instr got %h want 0", instr); end
        n_cmp++; if (instr_pc !== 32'h0) begin n_err++; $display("FAIL rst_instr_pc got %h want 0", instr_pc); end
    endtask

    task automatic test_sequence;
        int pw = 0;
        int got = 0;
        logic [31:0] exp;
        start(1'b1);
        for (int c = 0; c < 40 && got < 4; c++) begin
            if (c != 0) step;
            if (pc_write) pw++;
            if (instr_valid && instr_ready) begin
                exp = 32'(got * 4);
                n_cmp++; if (instr_pc !== exp) begin n_err++; $display("FAIL seq_pc got %h want %h", instr_pc, exp); end
                n_cmp++; if (instr !== (exp ^ 32'hA5A5_0000)) begin n_err++; $display("FAIL seq_instr got %h want %h", instr, exp ^ 32'hA5A5_0000); end
                got++;
            end
        end
        n_cmp++; if (got !== 4) begin n_err++; $display("FAIL seq_count got %0d want 4", got); end
`ifdef FETCH_BUF_EN
        n_cmp++; if (pw !== 6) begin n_err++; $display("FAIL seq_pc_writes got %0d want 6", pw); end
`else
        n_cmp++; if (pw !== 5) begin n_err++; $display("FAIL seq_pc_writes got %0d want 5", pw); end
`endif
    endtask

    task automatic test_stall_wait;
        start(1'b0);
        instr_ready = 1'b0;
        step;
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL wait_req0 got %b want 1", imem_req); end
        for (int i = 0; i < 3; i++) begin
            step; stall = 1'b1; #1;
            n_cmp++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL wait_hold%0d got %b/%h want 1/00000000", i, imem_req, imem_addr); end
            n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL wait_valid%0d got %b want 0", i, instr_valid); end
        end
        imem_ready = 1'b1; #1;
        n_cmp++; if ({pc_write, next_pc} !== {1'b1, 32'h4}) begin n_err++; $display("FAIL wait_pcw got %b/%h want 1/00000004", pc_write, next_pc); end
        step; imem_ready = 1'b0; #1;
        n_cmp++; if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h0, 32'hA5A5_0000}) begin n_err++; $display("FAIL wait_deliver got %b/%h/%h want 1/00000000/a5a50000", instr_valid, instr_pc, instr); end
        instr_ready = 1'b1;
        step;
        n_cmp++; if ({imem_req, instr_valid} !== 2'b00) begin n_err++; $display("FAIL stall_idle got %b%b want 00", imem_req, instr_valid); end
    endtask

    task automatic test_redirect_data;
        int found = 0;
        start(1'b1);
        step;
        redirect = 1'b1; redirect_pc = 32'h100; #1;
        n_cmp++; if ({pc_write, next_pc} !== {1'b1, 32'h100}) begin n_err++; $display("FAIL redir_pcw got %b/%h want 1/00000100", pc_write, next_pc); end
        step; redirect = 1'b0; #1;
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL redir_discard got %b want 0", instr_valid); end
        for (int c = 0; c < 10 && found == 0; c++) begin
            step;
            if (instr_valid) begin
                found = 1;
                n_cmp++; if ({instr_pc, instr} !== {32'h100, 32'hA5A5_0100}) begin n_err++; $display("FAIL redir_target got %h/%h want 00000100/a5a50100", instr_pc, instr); end
            end
        end
        n_cmp++; if (found !== 1) begin n_err++; $display("FAIL redir_timeout got %0d want 1", found); end
    endtask

    task automatic test_redirect_pending;
        start(1'b0);
        step; step;
        redirect = 1'b1; redirect_pc = 32'h200; #1;
        step; redirect = 1'b0; #1;
        n_cmp++; if ({imem_req, imem_addr} !== {1'b1, 32'h200}) begin n_err++; $display("FAIL pend_reissue got %b/%h want 1/00000200", imem_req, imem_addr); end
        imem_ready = 1'b1;
        step;
        n_cmp++; if ({instr_valid, instr_pc} !== {1'b1, 32'h200}) begin n_err++; $display("FAIL pend_deliver got %b/%h want 1/00000200", instr_valid, instr_pc); end
    endtask

    task automatic test_fault;
        start(1'b1);
        step;
        redirect = 1'b1; redirect_pc = 32'h102; #1;
        n_cmp++; if (pc_write !== 1'b0) begin n_err++; $display("FAIL fault_no_pcw got %b want 0", pc_write); end
        step; redirect_pc = 32'h200; #1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if ({fault, imem_req, pc_write, instr_valid} !== 4'b1000) begin n_err++; $display("FAIL halt%0d got %b want 1000", i, {fault, imem_req, pc_write, instr_valid}); end
            step;
        end
        redirect = 1'b0; rst_n = 1'b0; #1;
        n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL fault_clear got %b want 0", fault); end
        start(1'b1);
        n_cmp++; if ({pc_write, next_pc} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL restart_boot got %b/%h want 1/00000000", pc_write, next_pc); end
        step;
        n_cmp++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL restart_fetch got %b/%h want 1/00000000", imem_req, imem_addr); end
    endtask

    task automatic test_wrap;
        start(1'b1);
        step;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
        step; redirect = 1'b0; #1;
        n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_addr got %h want fffffffc", imem_addr); end
        n_cmp++; if ({pc_write, next_pc} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL wrap_next got %b/%h want 1/00000000", pc_write, next_pc); end
        step;
        n_cmp++; if ({instr_valid, instr_pc, imem_addr} !== {1'b1, 32'hFFFF_FFFC, 32'h0}) begin n_err++; $display("FAIL wrap_deliver got %b/%h/%h want 1/fffffffc/00000000", instr_valid, instr_pc, imem_addr); end
    endtask

`ifdef FETCH_BUF_EN
    task automatic test_buffer;
        int takes = 0;
        start(1'b1);
        instr_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step;
            if (imem_req && imem_ready) takes++;
        end
        n_cmp++; if (takes !== 2) begin n_err++; $display("FAIL buf_takes got %0d want 2", takes); end
        n_cmp++; if ({imem_req, instr_valid, instr_pc} !== {2'b01, 32'h0}) begin n_err++; $display("FAIL buf_full got %b%b/%h want 01/00000000", imem_req, instr_valid, instr_pc); end
        instr_ready = 1'b1; #1;
        step;
        n_cmp++; if ({instr_valid, instr_pc} !== {1'b1, 32'h4}) begin n_err++; $display("FAIL buf_order got %b/%h want 1/00000004", instr_valid, instr_pc); end
    endtask
`endif

    initial begin
        test_reset;
        test_sequence;
        test_stall_wait;
        test_redirect_data;
        test_redirect_pending;
        test_fault;
        test_wrap;
`ifdef FETCH_BUF_EN
        test_buffer;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end
endmodule
